mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port 64-bit word memory behind a valid/ready request
// channel and a valid/ready response channel. Each accepted request is
// answered LATENCY cycles later; one request is in flight at a time.
// Optional build macro: MEM_RESPONDER_ALIGN_CHECK_EN -- when defined, a request
// whose address is not 8-byte aligned is answered as an error instead of
// accessing the containing word.
module mem_responder #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int          DEPTH   = 512,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic            we_q;
  logic [63:0]     addr_q;
  logic [63:0]     wdata_q;
  logic [7:0]      wmask_q;
  logic [CW-1:0]   cnt;
  logic [63:0]     rdata_q;
  logic            err_q;
  logic [63:0]     mem [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic            mem_we;
  logic            cur_we;
  logic [63:0]     cur_addr;
  logic [63:0]     cur_wdata;
  logic [7:0]      cur_wmask;
  logic [63:0]     off;
  logic            in_range;
  logic            ok;
  logic [AW-1:0]   idx;

  // Effective request: live inputs while in IDLE (so LATENCY==1 can commit on
  // the acceptance edge), the captured copy once the request is in flight.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wmask = wmask_q;
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wmask = req_wmask;
    end
  end

  // Address decode: subtract-then-compare keeps the range test free of wrap.
  always_comb begin
    off      = cur_addr - BASE;
    in_range = (cur_addr >= BASE) && (off < SPAN);
    ok       = in_range;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ok       = in_range && (cur_addr[2:0] == 3'b000);
`endif
    idx      = off[AW+2:3];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: handshakes follow the state, response payload is registered.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);
  assign mem_we     = enter_resp && cur_we && ok && !rst;

  // Request capture, latency counter and response payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rdata_q <= (ok && !cur_we) ? mem[idx] : '0;
        err_q   <= !ok;
      end
    end
  end

  // Storage write port: byte-lane store committed on the edge entering RESP.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive rst, and an in-flight
    // store is dropped because rst both gates mem_we and returns to IDLE.
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (cur_wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array
// reference model, plus directed cases for the documented corner cases.
module tb_mem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] model [DEPTH];

  mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Legal access: inside [BASE, BASE + 8*DEPTH), and aligned when the check is built in.
  function automatic bit addr_ok(input logic [63:0] a);
    bit r;
    r = (a >= BASE) && ((a - BASE) < 64'(DEPTH) * 64'd8);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (a[2:0] != 3'b000) r = 1'b0;
`endif
    return r;
  endfunction

  // One complete transaction; hold = cycles to stall the response.
  task automatic xact(input bit we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] wm, input int hold, input string tag,
                      output logic [63:0] rd, output logic er);
    logic [63:0] exp_rd;
    logic        exp_err;
    int          w, n, k;
    exp_err = !addr_ok(a);
    exp_rd  = 64'd0;
    if (!exp_err) begin
      k = int'((a - BASE) >> 3);
      if (!we) exp_rd = model[k];
      else for (int i = 0; i < 8; i++) if (wm[i]) model[k][8*i +: 8] = wd[8*i +: 8];
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    check({tag, "/req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Garbage on the request bus while busy must be ignored.
    req_we = $urandom_range(1); req_addr = BASE + 64'($urandom_range(DEPTH - 1)) * 8;
    req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, "/latency"}, 64'(n), 64'(LAT));
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
    check({tag, "/err"}, 64'(rsp_err), 64'(exp_err));
    rd = rsp_rdata; er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "/hold_err"}, 64'(rsp_err), 64'(exp_err));
      check({tag, "/hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "/done_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "/done_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rd, a, v;
    logic        er;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/req_ready", 64'(req_ready), 64'd1);
    check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset/rsp_rdata", rsp_rdata, 64'd0);
    check("reset/rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;

    // Define every word before any load.
    for (int i = 0; i < DEPTH; i++)
      xact(1'b1, BASE + 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 0, "init", rd, er);

    // Full store then load, then partial-lane store.
    xact(1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 0, "st_full", rd, er);
    xact(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, "ld_full", rd, er);
    check("ld_full/const", rd, 64'h1122_3344_5566_7788);
    xact(1'b1, 64'h8000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, "st_lanes", rd, er);
    xact(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, "ld_lanes", rd, er);
    check("ld_lanes/const", rd, 64'h1122_3344_AAAA_AAAA);

    // Empty mask leaves the word unchanged.
    xact(1'b1, BASE + 16, 64'hDEAD_BEEF_0000_0001, 8'h00, 0, "st_nomask", rd, er);
    check("st_nomask/err", 64'(er), 64'd0);
    xact(1'b0, BASE + 16, 64'd0, 8'h00, 0, "ld_nomask", rd, er);

    // Out-of-range on both sides; out-of-range store must not touch word 511.
    xact(1'b1, BASE + 8 * 511, 64'h0511_0511_0511_0511, 8'hFF, 0, "st_w511", rd, er);
    xact(1'b0, 64'h8000_1000, 64'd0, 8'h00, 0, "ld_above", rd, er);
    check("ld_above/err_const", 64'(er), 64'd1);
    xact(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, "ld_below", rd, er);
    check("ld_below/err_const", 64'(er), 64'd1);
    xact(1'b1, 64'h8000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "st_above", rd, er);
    xact(1'b0, BASE + 8 * 511, 64'd0, 8'h00, 0, "ld_w511", rd, er);
    check("ld_w511/const", rd, 64'h0511_0511_0511_0511);

    // Response stall.
    xact(1'b0, 64'h8000_0000, 64'd0, 8'h00, 5, "stall", rd, er);

    // Reset while a store is in flight discards it.
    xact(1'b1, BASE + 8, 64'd0, 8'hFF, 0, "rst_pre", rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 8;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid/rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid/rsp_err", 64'(rsp_err), 64'd0);
    check("rst_mid/rsp_rdata", rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact(1'b0, BASE + 8, 64'd0, 8'h00, 0, "rst_post", rd, er);
    check("rst_post/const", rd, 64'd0);

    // Misaligned load.
    xact(1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "st_align", rd, er);
    xact(1'b0, 64'h8000_0004, 64'd0, 8'h00, 0, "ld_misalign", rd, er);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    check("ld_misalign/err_const", 64'(er), 64'd1);
`else
    check("ld_misalign/const", rd, 64'h0123_4567_89AB_CDEF);
`endif

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(9))
        0: a = BASE - 64'($urandom_range(1, 4)) * 8;
        1: a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 3)) * 8;
        2: a = {$urandom, $urandom};
        default: a = BASE + 64'($urandom_range(DEPTH - 1)) * 8
                     + (($urandom_range(3) == 0) ? 64'($urandom_range(7)) : 64'd0);
      endcase
      v = {$urandom, $urandom};
      xact(1'($urandom_range(1)), a, v,
           ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom),
           ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0,
           "rand", rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
